sap_ctrl_seq: RTL and testbench

- Control sequencer for the 4-bit SAP-style datapath.
- Runs a T1..T6 ring counter and decodes the instruction-register opcode into the control word for the whole datapath.
- Controlled registers: program counter, memory address register (`wa`), RAM, instruction register, accumulator, B register, ALU, output register.
- Sole source of the MAR load strobe; sequences every fetch and execute cycle.

---
 rtl/sap_pkg.sv | 34 +++
 rtl/sap_ctrl_seq_if.sv | 25 ++
 rtl/sap_ctrl_seq_ring.sv | 36 +++
 rtl/sap_ctrl_seq.sv | 114 +++++++++++
 tb/tb_sap_ctrl_seq.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared opcode, control-word and T-state constants for the SAP datapath
package sap_pkg;

    localparam int OPW_DEF = 4;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_W  = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_WA = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    localparam int TS_W = 6;
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

endpackage

// File: rtl/sap_ctrl_seq_if.sv
// rtl/sap_ctrl_seq_if.sv - opcode in, control word and ring state out
interface sap_ctrl_seq_if #(
    parameter int OPW = 4
);
    import sap_pkg::*;

    logic [OPW-1:0]  opcode;
    logic [CW_W-1:0] cw;
    logic [TS_W-1:0] tstate;
    logic            halt;

    modport master (
        output opcode,
        input  cw,
        input  tstate,
        input  halt
    );

    modport slave (
        input  opcode,
        output cw,
        output tstate,
        output halt
    );
endinterface

// File: rtl/sap_ctrl_seq_ring.sv
// rtl/sap_ctrl_seq_ring.sv - six-state one-hot ring counter with clear, hold and restart
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic            clk,
    input  logic            clr,
    input  logic            hold,
    input  logic            restart,
    output logic [TS_W-1:0] tstate
);

    logic [TS_W-1:0] ring_q;
    logic [TS_W-1:0] ring_d;

    // Next ring value: hold freezes, restart jumps to T1, otherwise rotate (T6 wraps to T1)
    always_comb begin
        ring_d = {ring_q[TS_W-2:0], ring_q[TS_W-1]};
        if (hold) begin
            ring_d = ring_q;
        end else if (restart) begin
            ring_d = TS_W'(1);
        end
    end

    // Ring register; clear overrides hold and restart
    always_ff @(posedge clk) begin
        if (clr) begin
            ring_q <= TS_W'(1);
        end else begin
            ring_q <= ring_d;
        end
    end

    assign tstate = ring_q;

endmodule

// File: rtl/sap_ctrl_seq.sv
// rtl/sap_ctrl_seq.sv - T-state sequencer and opcode decoder producing the datapath control word
module sap_ctrl_seq
    import sap_pkg::*;
#(
    parameter bit SKIP_IDLE = 1'b0,
    parameter int OPW       = 4
)(
    input  logic         clk,
    input  logic         clr,
    sap_ctrl_seq_if.slave bus
);

    localparam logic [OPW-1:0] L_LDA = OPW'(OP_LDA);
    localparam logic [OPW-1:0] L_ADD = OPW'(OP_ADD);
    localparam logic [OPW-1:0] L_SUB = OPW'(OP_SUB);
    localparam logic [OPW-1:0] L_OUT = OPW'(OP_OUT);
    localparam logic [OPW-1:0] L_HLT = OPW'(OP_HLT);

    logic [TS_W-1:0] tstate;
    logic            halt_q;
    logic            halt_d;
    logic            hold;
    logic            restart;
    logic            is_lda, is_add, is_sub, is_out, is_hlt, is_nop;
    logic [CW_W-1:0] cw;

    assign is_lda = (bus.opcode == L_LDA);
    assign is_add = (bus.opcode == L_ADD);
    assign is_sub = (bus.opcode == L_SUB);
    assign is_out = (bus.opcode == L_OUT);
    assign is_hlt = (bus.opcode == L_HLT);
    assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

    sap_ring_counter u_ring (
        .clk     (clk),
        .clr     (clr),
        .hold    (hold),
        .restart (restart),
        .tstate  (tstate)
    );

    // Freeze the ring once halted, and on the edge that enters halt from T4
    always_comb begin
        hold    = halt_q || (tstate[T4] && is_hlt);
        restart = 1'b0;
        if (SKIP_IDLE) begin
            restart = (tstate[T3] && is_nop) ||
                      (tstate[T4] && is_out) ||
                      (tstate[T5] && is_lda) ||
                      (tstate[T6] && (is_add || is_sub));
        end
        halt_d = halt_q || (tstate[T4] && is_hlt);
    end

    // Halt flag; only clr leaves the halted state
    always_ff @(posedge clk) begin
        if (clr) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    // Control-word decode from ring state and opcode; forced idle during clr or halt
    always_comb begin
        cw = '0;
        if (!clr && !halt_q) begin
            if (tstate[T1]) begin
                cw[CW_EP] = 1'b1;
                cw[CW_WA] = 1'b1;
            end
            if (tstate[T2]) begin
                cw[CW_CP] = 1'b1;
            end
            if (tstate[T3]) begin
                cw[CW_CE] = 1'b1;
                cw[CW_LI] = 1'b1;
            end
            if (tstate[T4]) begin
                if (is_lda || is_add || is_sub) begin
                    cw[CW_EI] = 1'b1;
                    cw[CW_WA] = 1'b1;
                end else if (is_out) begin
                    cw[CW_EA] = 1'b1;
                    cw[CW_LO] = 1'b1;
                end
            end
            if (tstate[T5]) begin
                if (is_lda) begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LA] = 1'b1;
                end else if (is_add || is_sub) begin
                    cw[CW_CE] = 1'b1;
                    cw[CW_LB] = 1'b1;
                end
            end
            if (tstate[T6] && (is_add || is_sub)) begin
                cw[CW_LA] = 1'b1;
                cw[CW_EU] = 1'b1;
                cw[CW_SU] = is_sub;
            end
        end
    end

    assign bus.cw     = cw;
    assign bus.tstate = tstate;
    assign bus.halt   = halt_q;

    // Ring must stay one-hot and at most one bus driver may be enabled
    a_onehot: assert property (@(posedge clk) disable iff (clr) $onehot(tstate));
    a_one_driver: assert property (@(posedge clk)
        $onehot0({cw[CW_EP], cw[CW_CE], cw[CW_EI], cw[CW_EA], cw[CW_EU]}));

endmodule

// File: tb/tb_sap_ctrl_seq.sv
// tb/tb_sap_ctrl_seq.sv - directed self-checking bench for the SAP control sequencer
module tb_sap_ctrl_seq;
    import sap_pkg::*;

    logic clk;
    logic clr;
    int   n_checks;
    int   n_fail;

    sap_ctrl_seq_if #(.OPW(4)) b0 ();
    sap_ctrl_seq_if #(.OPW(4)) b1 ();

    sap_ctrl_seq #(.SKIP_IDLE(1'b0), .OPW(4)) u_dut (
        .clk (clk),
        .clr (clr),
        .bus (b0)
    );

    sap_ctrl_seq #(.SKIP_IDLE(1'b1), .OPW(4)) u_skip (
        .clk (clk),
        .clr (clr),
        .bus (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_t4();
        tick(); tick(); tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        clr       = 1'b1;
        b0.opcode = 4'h0;
        b1.opcode = 4'hE;

        // reset held for two cycles
        tick();
        check_eq("clr_cw_c1", 16'(b0.cw), 16'h000);
        tick();
        check_eq("clr_tstate", 16'(b0.tstate), 16'h01);
        check_eq("clr_halt", 16'(b0.halt), 16'h0);
        check_eq("clr_cw", 16'(b0.cw), 16'h000);
        check_eq("skip_clr_tstate", 16'(b1.tstate), 16'h01);

        // LDA through all six states; skip instance runs OUT alongside
        clr = 1'b0;
        #1;
        check_eq("lda_t1", 16'(b0.cw), 16'h600);
        tick();
        check_eq("lda_t2", 16'(b0.cw), 16'h800);
        tick();
        check_eq("lda_t3", 16'(b0.cw), 16'h180);
        tick();
        check_eq("lda_t4", 16'(b0.cw), 16'h240);
        check_eq("skip_out_t4_state", 16'(b1.tstate), 16'h08);
        check_eq("skip_out_t4_cw", 16'(b1.cw), 16'h011);
        tick();
        check_eq("lda_t5", 16'(b0.cw), 16'h120);
        check_eq("lda_t5_state", 16'(b0.tstate), 16'h10);
        check_eq("skip_out_restart", 16'(b1.tstate), 16'h01);
        check_eq("skip_out_t1_cw", 16'(b1.cw), 16'h600);
        tick();
        check_eq("lda_t6", 16'(b0.cw), 16'h000);
        check_eq("lda_t6_state", 16'(b0.tstate), 16'h20);
        tick();
        check_eq("lda_wrap", 16'(b0.tstate), 16'h01);

        // opcode toggling during fetch must not disturb cw, then ADD
        b0.opcode = 4'h5;
        #1;
        check_eq("tog_t1", 16'(b0.cw), 16'h600);
        tick();
        b0.opcode = 4'hF;
        #1;
        check_eq("tog_t2", 16'(b0.cw), 16'h800);
        tick();
        b0.opcode = 4'h2;
        #1;
        check_eq("tog_t3a", 16'(b0.cw), 16'h180);
        b0.opcode = 4'h1;
        #1;
        check_eq("tog_t3b", 16'(b0.cw), 16'h180);
        tick();
        check_eq("add_t4", 16'(b0.cw), 16'h240);
        tick();
        check_eq("add_t5", 16'(b0.cw), 16'h102);
        tick();
        check_eq("add_t6", 16'(b0.cw), 16'h024);
        tick();
        check_eq("add_wrap", 16'(b0.tstate), 16'h01);

        // SUB
        b0.opcode = 4'h2;
        run_to_t4();
        check_eq("sub_t4", 16'(b0.cw), 16'h240);
        tick();
        check_eq("sub_t5", 16'(b0.cw), 16'h102);
        tick();
        check_eq("sub_t6", 16'(b0.cw), 16'h02C);
        tick();

        // OUT without skipping
        b0.opcode = 4'hE;
        run_to_t4();
        check_eq("out_t4", 16'(b0.cw), 16'h011);
        tick();
        check_eq("out_t5", 16'(b0.cw), 16'h000);
        check_eq("out_t5_state", 16'(b0.tstate), 16'h10);
        tick();
        check_eq("out_t6", 16'(b0.cw), 16'h000);
        tick();

        // unknown opcode acts as NOP
        b0.opcode = 4'h5;
        run_to_t4();
        check_eq("nop_t4", 16'(b0.cw), 16'h000);
        tick();
        check_eq("nop_t5", 16'(b0.cw), 16'h000);
        tick();
        check_eq("nop_t6", 16'(b0.cw), 16'h000);
        tick();
        check_eq("nop_wrap", 16'(b0.tstate), 16'h01);

        // reset in the middle of an ADD
        b0.opcode = 4'h1;
        run_to_t4();
        tick();
        check_eq("mid_t5", 16'(b0.cw), 16'h102);
        clr = 1'b1;
        #1;
        check_eq("mid_clr_cw", 16'(b0.cw), 16'h000);
        tick();
        check_eq("mid_clr_state", 16'(b0.tstate), 16'h01);
        clr = 1'b0;
        #1;

        // HLT: freeze at T4 with cw idle, opcode ignored
        b0.opcode = 4'hF;
        run_to_t4();
        check_eq("hlt_t4_cw", 16'(b0.cw), 16'h000);
        check_eq("hlt_t4_halt", 16'(b0.halt), 16'h0);
        tick();
        check_eq("hlt_halt", 16'(b0.halt), 16'h1);
        check_eq("hlt_state", 16'(b0.tstate), 16'h08);
        for (int i = 0; i < 10; i++) begin
            b0.opcode = 4'(i);
            tick();
            check_eq("hlt_hold_state", 16'(b0.tstate), 16'h08);
            check_eq("hlt_hold_cw", 16'(b0.cw), 16'h000);
            check_eq("hlt_hold_halt", 16'(b0.halt), 16'h1);
        end
        clr = 1'b1;
        tick();
        check_eq("hlt_exit_halt", 16'(b0.halt), 16'h0);
        check_eq("hlt_exit_state", 16'(b0.tstate), 16'h01);
        clr = 1'b0;
        #1;
        check_eq("hlt_exit_t1", 16'(b0.cw), 16'h600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
